// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types and defaults for the NPC register write-back controller.
// The WB_BYPASS_EN build option is honoured by wb_scoreboard and reg_writeback_ctrl.
package npc_wb_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_EXU,
    WB_SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of issue, result-handshake, write-port, bypass and commit signals.
// The slave modport is the controller's view; master is the surrounding core's view.
interface reg_writeback_ctrl_if
  import npc_wb_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
);
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          hazard;
  logic          exu_valid;
  logic          exu_ready;
  logic [AW-1:0] exu_rd;
  logic [DW-1:0] exu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          byp1_valid;
  logic [DW-1:0] byp1_data;
  logic          byp2_valid;
  logic [DW-1:0] byp2_data;
  logic          commit_valid;
  logic [AW-1:0] commit_rd;
  logic          sb_err;

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  hazard, exu_ready, lsu_ready, wen, waddr, wdata,
    input  byp1_valid, byp1_data, byp2_valid, byp2_data,
    input  commit_valid, commit_rd, sb_err
  );

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output hazard, exu_ready, lsu_ready, wen, waddr, wdata,
    output byp1_valid, byp1_data, byp2_valid, byp2_data,
    output commit_valid, commit_rd, sb_err
  );
endinterface

// File: rtl/reg_writeback_ctrl_scoreboard.sv
// Per-register pending scoreboard: set on issue, clear on write-back, RAW/WAW hazard.
// With WB_BYPASS_EN a register being written this cycle is no longer treated as pending.
module wb_scoreboard
  import npc_wb_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  output logic          hazard,
  output logic          sb_err
);
  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NREG-1:0] pending_q, pending_d, pend_eff;
  logic            sb_err_q, sb_err_d;
  logic            set_hit, clr_hit;

  assign set_hit = issue_valid && (issue_rd != ZERO);
  assign clr_hit = wen && (waddr != ZERO);

  always_comb begin
    pending_d = pending_q;
    if (clr_hit) pending_d[waddr] = 1'b0;
    // Applied after the clear so a same-edge set on the same register wins.
    if (set_hit) pending_d[issue_rd] = 1'b1;
    sb_err_d = sb_err_q
             | (set_hit && pending_q[issue_rd] && !(clr_hit && waddr == issue_rd));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
`ifdef WB_BYPASS_EN
    assign pend_eff[gi] = pending_q[gi] && !(wen && waddr == AW'(gi));
`else
    assign pend_eff[gi] = pending_q[gi];
`endif
  end

  assign hazard = ((rs1 != ZERO) && pend_eff[rs1])
                | ((rs2 != ZERO) && pend_eff[rs2])
                | ((issue_rd != ZERO) && pend_eff[issue_rd]);
  assign sb_err = sb_err_q;
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-back controller: LSU-priority arbiter, registered write port,
// commit pulse and scoreboard; WB_BYPASS_EN adds same-cycle write-data bypass.
module reg_writeback_ctrl
  import npc_wb_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_writeback_ctrl_if.slave  bus
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  wb_src_e       src;
  logic [AW-1:0] acc_rd;
  logic [DW-1:0] acc_data;

  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          commit_valid_q, commit_valid_d;
  logic [AW-1:0] commit_rd_q, commit_rd_d;
  logic          sb_hazard, sb_err_w;

  always_comb begin
    src      = WB_SRC_NONE;
    acc_rd   = ZERO;
    acc_data = '0;
    if (bus.lsu_valid) begin
      src      = WB_SRC_LSU;
      acc_rd   = bus.lsu_rd;
      acc_data = bus.lsu_data;
    end else if (bus.exu_valid) begin
      src      = WB_SRC_EXU;
      acc_rd   = bus.exu_rd;
      acc_data = bus.exu_data;
    end
  end

  always_comb begin
    // x0 results still retire through the commit pulse but never write.
    wen_d          = (src != WB_SRC_NONE) && (acc_rd != ZERO);
    waddr_d        = (src != WB_SRC_NONE) ? acc_rd : waddr_q;
    wdata_d        = (src != WB_SRC_NONE) ? acc_data : wdata_q;
    commit_valid_d = (src != WB_SRC_NONE);
    commit_rd_d    = (src != WB_SRC_NONE) ? acc_rd : ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q          <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
    end else begin
      wen_q          <= wen_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
    end
  end

  wb_scoreboard #(.AW(AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(bus.issue_valid),
    .issue_rd   (bus.issue_rd),
    .rs1        (bus.rs1),
    .rs2        (bus.rs2),
    .wen        (wen_q),
    .waddr      (waddr_q),
    .hazard     (sb_hazard),
    .sb_err     (sb_err_w)
  );

  assign bus.lsu_ready    = 1'b1;
  assign bus.exu_ready    = !bus.lsu_valid;
  assign bus.wen          = wen_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.hazard       = sb_hazard;
  assign bus.sb_err       = sb_err_w;

`ifdef WB_BYPASS_EN
  assign bus.byp1_valid = wen_q && (waddr_q == bus.rs1) && (bus.rs1 != ZERO);
  assign bus.byp1_data  = wdata_q;
  assign bus.byp2_valid = wen_q && (waddr_q == bus.rs2) && (bus.rs2 != ZERO);
  assign bus.byp2_data  = wdata_q;
`else
  assign bus.byp1_valid = 1'b0;
  assign bus.byp1_data  = '0;
  assign bus.byp2_valid = 1'b0;
  assign bus.byp2_data  = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios plus randomized
// traffic checked against an array-based model of the write-back rules.
module tb_reg_writeback_ctrl;
  import npc_wb_pkg::*;

  localparam int AW   = ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 1 << AW;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if bus ();

  reg_writeback_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    bus.rs1 = 5'd3;
    #1;
    $display("reset: wen=%0b commit=%0b sb_err=%0b hazard=%0b", bus.wen, bus.commit_valid, bus.sb_err, bus.hazard);
    n_checks++; if (bus.wen !== 1'b0) $display("FAIL reset_wen: got %0b want 0", bus.wen); else n_pass++;
    n_checks++; if (bus.commit_valid !== 1'b0) $display("FAIL reset_commit: got %0b want 0", bus.commit_valid); else n_pass++;
    n_checks++; if (bus.sb_err !== 1'b0) $display("FAIL reset_sb_err: got %0b want 0", bus.sb_err); else n_pass++;
    n_checks++; if (bus.hazard !== 1'b0) $display("FAIL reset_hazard: got %0b want 0", bus.hazard); else n_pass++;
    n_checks++; if (bus.byp1_valid !== 1'b0) $display("FAIL reset_byp1: got %0b want 0", bus.byp1_valid); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_exu_write();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h1234;
    #1;
    n_checks++; if (bus.exu_ready !== 1'b1) $display("FAIL exu_ready: got %0b want 1", bus.exu_ready); else n_pass++;
    tick();
    idle();
    $display("exu write: wen=%0b waddr=%0d wdata=%h commit=%0b rd=%0d", bus.wen, bus.waddr, bus.wdata, bus.commit_valid, bus.commit_rd);
    n_checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd5 || bus.wdata !== 32'h1234)
      $display("FAIL exu_write: got wen=%0b waddr=%0d wdata=%h want 1/5/1234", bus.wen, bus.waddr, bus.wdata); else n_pass++;
    n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd5)
      $display("FAIL exu_commit: got %0b/%0d want 1/5", bus.commit_valid, bus.commit_rd); else n_pass++;
    tick();
    n_checks++; if (bus.wen !== 1'b0 || bus.commit_valid !== 1'b0)
      $display("FAIL exu_idle: got wen=%0b commit=%0b want 0/0", bus.wen, bus.commit_valid); else n_pass++;
  endtask

  task automatic test_arbitration();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'hAAAA_0003;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hBBBB_0004;
    #1;
    n_checks++; if (bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b1)
      $display("FAIL arb_ready: got exu=%0b lsu=%0b want 0/1", bus.exu_ready, bus.lsu_ready); else n_pass++;
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    $display("arb first: waddr=%0d wdata=%h", bus.waddr, bus.wdata);
    n_checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd4 || bus.wdata !== 32'hBBBB_0004)
      $display("FAIL arb_lsu_first: got %0b/%0d/%h want 1/4/bbbb0004", bus.wen, bus.waddr, bus.wdata); else n_pass++;
    n_checks++; if (bus.exu_ready !== 1'b1) $display("FAIL arb_exu_ready2: got %0b want 1", bus.exu_ready); else n_pass++;
    tick();
    idle();
    $display("arb second: waddr=%0d wdata=%h", bus.waddr, bus.wdata);
    n_checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 32'hAAAA_0003)
      $display("FAIL arb_exu_second: got %0b/%0d/%h want 1/3/aaaa0003", bus.wen, bus.waddr, bus.wdata); else n_pass++;
    tick();
  endtask

  task automatic test_hazard();
    logic exp_hz;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    #1;
    n_checks++; if (bus.hazard !== 1'b0) $display("FAIL hz_issue_cycle: got %0b want 0", bus.hazard); else n_pass++;
    tick();
    idle();
    bus.rs1 = 5'd7;
    #1;
    n_checks++; if (bus.hazard !== 1'b1) $display("FAIL hz_raw: got %0b want 1", bus.hazard); else n_pass++;
    tick(); tick();
    n_checks++; if (bus.hazard !== 1'b1) $display("FAIL hz_hold: got %0b want 1", bus.hazard); else n_pass++;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h0000_0077;
    tick();
    bus.exu_valid = 1'b0;
    #1;
    exp_hz = !BYP;
    $display("hazard wen cycle: hazard=%0b byp1=%0b data=%h", bus.hazard, bus.byp1_valid, bus.byp1_data);
    n_checks++; if (bus.hazard !== exp_hz) $display("FAIL hz_wen_cycle: got %0b want %0b", bus.hazard, exp_hz); else n_pass++;
    n_checks++; if (bus.byp1_valid !== BYP) $display("FAIL hz_byp1_valid: got %0b want %0b", bus.byp1_valid, BYP); else n_pass++;
    n_checks++; if (bus.byp1_data !== (BYP ? 32'h77 : 32'h0)) $display("FAIL hz_byp1_data: got %h", bus.byp1_data); else n_pass++;
    tick();
    n_checks++; if (bus.hazard !== 1'b0) $display("FAIL hz_after_wb: got %0b want 0", bus.hazard); else n_pass++;
    idle();
  endtask

  task automatic test_rd_zero();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'hFFFF;
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    #1;
    $display("rd0 result: wen=%0b commit=%0b rd=%0d", bus.wen, bus.commit_valid, bus.commit_rd);
    n_checks++; if (bus.wen !== 1'b0) $display("FAIL rd0_wen: got %0b want 0", bus.wen); else n_pass++;
    n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd0)
      $display("FAIL rd0_commit: got %0b/%0d want 1/0", bus.commit_valid, bus.commit_rd); else n_pass++;
    tick();
    bus.issue_valid = 1'b0;
    #1;
    n_checks++; if (bus.hazard !== 1'b0) $display("FAIL rd0_hazard: got %0b want 0", bus.hazard); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_sb_err();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    n_checks++; if (bus.sb_err !== 1'b0) $display("FAIL sberr_first: got %0b want 0", bus.sb_err); else n_pass++;
    tick();
    idle();
    $display("double issue rd9: sb_err=%0b", bus.sb_err);
    n_checks++; if (bus.sb_err !== 1'b1) $display("FAIL sberr_set: got %0b want 1", bus.sb_err); else n_pass++;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h9;
    tick();
    idle();
    repeat (3) tick();
    n_checks++; if (bus.sb_err !== 1'b1) $display("FAIL sberr_sticky: got %0b want 1", bus.sb_err); else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
    tick();
    idle();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h00AA;
    tick();
    idle();
    bus.rs1 = 5'd2;
    #1;
    n_checks++; if (bus.wen !== 1'b1 || bus.hazard !== 1'b1)
      $display("FAIL areset_pre: got wen=%0b hazard=%0b want 1/1", bus.wen, bus.hazard); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset: wen=%0b waddr=%0d wdata=%h commit=%0b sb_err=%0b", bus.wen, bus.waddr, bus.wdata, bus.commit_valid, bus.sb_err);
    n_checks++; if (bus.wen !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0)
      $display("FAIL areset_wport: got %0b/%0d/%h want 0/0/0", bus.wen, bus.waddr, bus.wdata); else n_pass++;
    n_checks++; if (bus.commit_valid !== 1'b0 || bus.commit_rd !== '0 || bus.sb_err !== 1'b0)
      $display("FAIL areset_misc: got commit=%0b rd=%0d sb_err=%0b want 0/0/0", bus.commit_valid, bus.commit_rd, bus.sb_err); else n_pass++;
    n_checks++; if (bus.hazard !== 1'b0) $display("FAIL areset_hazard_low: got %0b want 0", bus.hazard); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.hazard !== 1'b0) $display("FAIL areset_hazard_rel: got %0b want 0", bus.hazard); else n_pass++;
    idle();
    tick();
  endtask

  function automatic bit model_pend(bit pend[NREG], bit w, logic [AW-1:0] wa, logic [AW-1:0] r);
    return (r != 0) && pend[r] && !(BYP && w && wa == r);
  endfunction

  task automatic test_random();
    bit            m_pend[NREG];
    bit            m_wen, m_cv, m_err, exp_hz, exp_b1, exp_b2;
    bit            win;
    logic [AW-1:0] m_waddr, m_crd, w_rd;
    logic [DW-1:0] m_wdata, w_data;
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_wen = 0; m_cv = 0; m_err = 0; m_waddr = '0; m_crd = '0; m_wdata = '0;
    for (int i = 0; i < 400; i++) begin
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_rd    = AW'($urandom_range(0, 7));
      bus.rs1         = AW'($urandom_range(0, 7));
      bus.rs2         = AW'($urandom_range(0, 7));
      bus.exu_valid   = 1'($urandom_range(0, 1));
      bus.exu_rd      = AW'($urandom_range(0, 7));
      bus.exu_data    = $urandom;
      bus.lsu_valid   = ($urandom_range(0, 3) == 0);
      bus.lsu_rd      = AW'($urandom_range(0, 7));
      bus.lsu_data    = $urandom;
      #1;
      exp_hz = model_pend(m_pend, m_wen, m_waddr, bus.rs1) || model_pend(m_pend, m_wen, m_waddr, bus.rs2)
            || model_pend(m_pend, m_wen, m_waddr, bus.issue_rd);
      exp_b1 = BYP && m_wen && m_waddr == bus.rs1 && bus.rs1 != 0;
      exp_b2 = BYP && m_wen && m_waddr == bus.rs2 && bus.rs2 != 0;
      n_checks++; if (bus.exu_ready !== !bus.lsu_valid) $display("FAIL rnd_exu_ready[%0d]: got %0b want %0b", i, bus.exu_ready, !bus.lsu_valid); else n_pass++;
      n_checks++; if (bus.hazard !== exp_hz) $display("FAIL rnd_hazard[%0d]: got %0b want %0b", i, bus.hazard, exp_hz); else n_pass++;
      n_checks++; if (bus.byp1_valid !== exp_b1 || bus.byp2_valid !== exp_b2)
        $display("FAIL rnd_byp_valid[%0d]: got %0b/%0b want %0b/%0b", i, bus.byp1_valid, bus.byp2_valid, exp_b1, exp_b2); else n_pass++;
      if (exp_b1) begin
        n_checks++; if (bus.byp1_data !== m_wdata) $display("FAIL rnd_byp1_data[%0d]: got %h want %h", i, bus.byp1_data, m_wdata); else n_pass++;
      end
      n_checks++; if (bus.wen !== m_wen) $display("FAIL rnd_wen[%0d]: got %0b want %0b", i, bus.wen, m_wen); else n_pass++;
      if (m_wen) begin
        n_checks++; if (bus.waddr !== m_waddr || bus.wdata !== m_wdata)
          $display("FAIL rnd_wport[%0d]: got %0d/%h want %0d/%h", i, bus.waddr, bus.wdata, m_waddr, m_wdata); else n_pass++;
      end
      n_checks++; if (bus.commit_valid !== m_cv || (m_cv && bus.commit_rd !== m_crd))
        $display("FAIL rnd_commit[%0d]: got %0b/%0d want %0b/%0d", i, bus.commit_valid, bus.commit_rd, m_cv, m_crd); else n_pass++;
      n_checks++; if (bus.sb_err !== m_err) $display("FAIL rnd_sb_err[%0d]: got %0b want %0b", i, bus.sb_err, m_err); else n_pass++;

      win    = bus.lsu_valid || bus.exu_valid;
      w_rd   = bus.lsu_valid ? bus.lsu_rd : bus.exu_rd;
      w_data = bus.lsu_valid ? bus.lsu_data : bus.exu_data;
      if (win) $display("rnd %0d: accept %s rd=%0d data=%h", i, bus.lsu_valid ? "lsu" : "exu", w_rd, w_data);
      if (bus.issue_valid && bus.issue_rd != 0 && m_pend[bus.issue_rd] && !(m_wen && m_waddr == bus.issue_rd))
        m_err = 1'b1;
      if (m_wen) m_pend[m_waddr] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
      m_wen = win && (w_rd != 0);
      if (win) begin
        m_waddr = w_rd;
        m_wdata = w_data;
      end
      m_cv  = win;
      m_crd = win ? w_rd : '0;
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_exu_write();
    test_arbitration();
    test_hazard();
    test_rd_zero();
    test_sb_err();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
